uart_rx_param: RTL

Parametrised UART receiver, successor to the fixed 8N1 receiver. It integrates its own oversampling baud-tick generator. Frame format is configurable: data width, parity mode and stop-bit count. Each bit is majority-voted, and the block reports framing, parity, break and overrun errors. Received words are delivered over a valid/ready interface with a one-entry holding register, for consumption by the logic-analyser command path or a FIFO.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_rx_param_if.sv | 25 ++
 rtl/uart_baud_tick.sv | 29 ++
 rtl/uart_rx_param.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, parity modes, divider helper.
// Used by the parametrised receiver and the matching transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Rounded clocks per oversampling tick.
    function automatic int calc_div(input int clk_freq, input int baud,
                                    input int os);
        int den;
        den = baud * os;
        return (clk_freq + den / 2) / den;
    endfunction

endpackage

// File: rtl/uart_rx_param_if.sv
// Receive-side valid/ready bundle: word, error flags and handshake.
// The receiver drives it as master, the consumer as slave.
interface uart_rx_param_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 parity_err;
    logic                 frame_err;
    logic                 break_det;
    logic                 overrun;

    modport master (
        output rx_data, rx_valid, parity_err, frame_err,
        output break_det, overrun,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, parity_err, frame_err,
        input  break_det, overrun,
        output rx_ready
    );
endinterface

// File: rtl/uart_baud_tick.sv
// Oversampling tick divider: counts 0..DIV-1, pulses tick at DIV-1.
// clr_i restarts the count so ticks align to a detected edge.
module uart_baud_tick #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    output logic tick_o
);
    localparam int CW = $clog2(DIV);

    logic [CW-1:0] cnt_q;
    logic          at_end;

    assign at_end = (cnt_q == CW'(DIV - 1));
    assign tick_o = at_end && !clr_i;

    // Free-running divider with synchronous restart.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr_i || at_end) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with majority-voted oversampling,
// parity/framing/break/overrun detection and a one-word holding register.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rs232_rx,
    output logic busy,
    uart_rx_param_if.master rx_if
);
    localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int M   = OVERSAMPLE / 2;
    localparam int SW  = $clog2(OVERSAMPLE);
    localparam int BW  = $clog2(DATA_BITS);

    if (DIV < 2) begin : g_div_chk
        $error("uart_rx_param: clock too slow, DIV < 2");
    end
    if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_os_chk
        $error("uart_rx_param: OVERSAMPLE must be even and >= 8");
    end
    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_db_chk
        $error("uart_rx_param: DATA_BITS must be 5..8");
    end
    if (PARITY > PAR_EVEN || PARITY < PAR_NONE) begin : g_par_chk
        $error("uart_rx_param: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_stop_chk
        $error("uart_rx_param: STOP_BITS must be 1 or 2");
    end

    logic [1:0]           sync_q;
    logic                 rx_s;
    state_e               state_q;
    logic [SW-1:0]        scnt_q;
    logic [BW-1:0]        bidx_q;
    logic                 sidx_q;
    logic [1:0]           s_q;
    logic [DATA_BITS-1:0] shreg_q;
    logic                 par_bad_q;
    logic                 par_bit_q;
    logic                 ferr_pend_q;
    logic                 stop1_q;
    logic                 armed_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 perr_q;
    logic                 ferr_q;
    logic                 brk_q;
    logic                 ovr_q;

    logic tick;
    logic clr;
    logic vote;
    logic mid;
    logic wrap;
    logic last_stop;
    logic stop1;
    logic brk;

    assign rx_s      = sync_q[1];
    assign clr       = (state_q == IDLE) && armed_q && !rx_s;
    assign vote      = (s_q[0] & s_q[1]) | (s_q[0] & rx_s) | (s_q[1] & rx_s);
    assign mid       = tick && (scnt_q == SW'(M + 1));
    assign wrap      = tick && (scnt_q == SW'(OVERSAMPLE - 1));
    assign last_stop = (sidx_q == 1'(STOP_BITS - 1));
    assign stop1     = (sidx_q == 1'b0) ? vote : stop1_q;
    assign brk       = (shreg_q == '0) && !par_bit_q && !stop1;
    assign busy      = (state_q != IDLE);

    assign rx_if.rx_data    = data_q;
    assign rx_if.rx_valid   = valid_q;
    assign rx_if.parity_err = perr_q;
    assign rx_if.frame_err  = ferr_q;
    assign rx_if.break_det  = brk_q;
    assign rx_if.overrun    = ovr_q;

    uart_baud_tick #(
        .DIV(DIV)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (clr),
        .tick_o(tick)
    );

    // Two-flop synchroniser for the asynchronous line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rs232_rx};
        end
    end

    // Frame FSM, bit sampling and the output holding register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            scnt_q      <= '0;
            bidx_q      <= '0;
            sidx_q      <= 1'b0;
            s_q         <= 2'b11;
            shreg_q     <= '0;
            par_bad_q   <= 1'b0;
            par_bit_q   <= 1'b0;
            ferr_pend_q <= 1'b0;
            stop1_q     <= 1'b0;
            armed_q     <= 1'b1;
            data_q      <= '0;
            valid_q     <= 1'b0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
            brk_q       <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            if (tick && scnt_q == SW'(M - 1)) s_q[0] <= rx_s;
            if (tick && scnt_q == SW'(M))     s_q[1] <= rx_s;

            if (state_q != IDLE && tick) begin
                scnt_q <= (scnt_q == SW'(OVERSAMPLE - 1)) ? '0 : scnt_q + 1'b1;
            end

            if (valid_q && rx_if.rx_ready) begin
                valid_q <= 1'b0;
                perr_q  <= 1'b0;
                ferr_q  <= 1'b0;
                brk_q   <= 1'b0;
                ovr_q   <= 1'b0;
            end

            if (!armed_q && tick && rx_s) armed_q <= 1'b1;

            unique case (state_q)
                IDLE: begin
                    if (clr) begin
                        state_q     <= START;
                        scnt_q      <= '0;
                        par_bad_q   <= 1'b0;
                        par_bit_q   <= 1'b0;
                        ferr_pend_q <= 1'b0;
                    end
                end
                START: begin
                    if (mid && vote) begin
                        state_q <= IDLE;
                    end else if (wrap) begin
                        state_q <= DATA;
                        bidx_q  <= '0;
                    end
                end
                DATA: begin
                    if (mid) shreg_q <= {vote, shreg_q[DATA_BITS-1:1]};
                    if (wrap) begin
                        if (bidx_q == BW'(DATA_BITS - 1)) begin
                            state_q <= (PARITY != PAR_NONE) ? uart_pkg::PARITY : STOP;
                            sidx_q  <= 1'b0;
                        end else begin
                            bidx_q <= bidx_q + 1'b1;
                        end
                    end
                end
                uart_pkg::PARITY: begin
                    if (mid) begin
                        par_bit_q <= vote;
                        par_bad_q <= ((^shreg_q) ^ vote) != (PARITY == PAR_ODD);
                    end
                    if (wrap) begin
                        state_q <= STOP;
                        sidx_q  <= 1'b0;
                    end
                end
                STOP: begin
                    if (mid && last_stop) begin
                        // Commit half a bit early so the next start edge is caught.
                        state_q <= IDLE;
                        data_q  <= shreg_q;
                        valid_q <= 1'b1;
                        perr_q  <= par_bad_q;
                        ferr_q  <= ferr_pend_q | !vote;
                        brk_q   <= brk;
                        ovr_q   <= valid_q && !rx_if.rx_ready;
                        armed_q <= !brk;
                    end else begin
                        if (mid) begin
                            ferr_pend_q <= ferr_pend_q | !vote;
                            stop1_q     <= vote;
                        end
                        if (wrap) sidx_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
